// File: rtl/z80_mem_read_cycle.sv
// Z80 memory read machine cycle sequencer: plain reads (T1-T2-TW*-T3) and
// opcode fetches with refresh (T1-T2-TW*-T3-T4). Every output comes straight from a flop.
module z80_mem_read_cycle (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        m1,
  input  logic [15:0] addr,
  input  logic [15:0] rfsh_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  data_out,
  output logic [15:0] bus_a,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        m1_n,
  output logic        rfsh_n,
  input  logic [7:0]  bus_d,
  input  logic        wait_n
);

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3,
    T4
  } state_e;

  state_e      state_q, state_d;
  logic        m1_q, m1_d;
  logic [15:0] rfsh_q, rfsh_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] bus_a_q, bus_a_d;
  logic        mreq_n_q, mreq_n_d;
  logic        rd_n_q, rd_n_d;
  logic        m1_n_q, m1_n_d;
  logic        rfsh_n_q, rfsh_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // bus_a_q doubles as the latched read address, so no separate copy is kept.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    m1_d     = m1_q;
    rfsh_d   = rfsh_q;
    data_d   = data_q;
    bus_a_d  = bus_a_q;
    mreq_n_d = mreq_n_q;
    rd_n_d   = rd_n_q;
    m1_n_d   = m1_n_q;
    rfsh_n_d = rfsh_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = T1;
          m1_d     = m1;
          rfsh_d   = rfsh_addr;
          bus_a_d  = addr;
          mreq_n_d = 1'b0;
          rd_n_d   = 1'b0;
          m1_n_d   = ~m1;
          rfsh_n_d = 1'b1;
          busy_d   = 1'b1;
        end
      end

      T1: state_d = T2;

      T2, TW: begin
        if (!wait_n) begin
          state_d = TW;
        end else begin
          state_d = T3;
          // Opcode fetch samples the bus early and turns the bus over to refresh for T3/T4.
          if (m1_q) begin
            data_d   = bus_d;
            rd_n_d   = 1'b1;
            m1_n_d   = 1'b1;
            bus_a_d  = rfsh_q;
            rfsh_n_d = 1'b0;
            mreq_n_d = 1'b0;
          end
        end
      end

      T3: begin
        if (m1_q) begin
          state_d  = T4;
          mreq_n_d = 1'b1;
        end else begin
          state_d  = IDLE;
          data_d   = bus_d;
          mreq_n_d = 1'b1;
          rd_n_d   = 1'b1;
          bus_a_d  = 16'h0000;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end

      T4: begin
        state_d  = IDLE;
        rfsh_n_d = 1'b1;
        bus_a_d  = 16'h0000;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end

      default: begin
        state_d  = IDLE;
        bus_a_d  = 16'h0000;
        mreq_n_d = 1'b1;
        rd_n_d   = 1'b1;
        m1_n_d   = 1'b1;
        rfsh_n_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      m1_q     <= 1'b0;
      rfsh_q   <= 16'h0000;
      data_q   <= 8'h00;
      bus_a_q  <= 16'h0000;
      mreq_n_q <= 1'b1;
      rd_n_q   <= 1'b1;
      m1_n_q   <= 1'b1;
      rfsh_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m1_q     <= m1_d;
      rfsh_q   <= rfsh_d;
      data_q   <= data_d;
      bus_a_q  <= bus_a_d;
      mreq_n_q <= mreq_n_d;
      rd_n_q   <= rd_n_d;
      m1_n_q   <= m1_n_d;
      rfsh_n_q <= rfsh_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_q;
  assign bus_a    = bus_a_q;
  assign mreq_n   = mreq_n_q;
  assign rd_n     = rd_n_q;
  assign m1_n     = m1_n_q;
  assign rfsh_n   = rfsh_n_q;

endmodule

// File: tb/tb_z80_mem_read_cycle.sv
// Bench for z80_mem_read_cycle: directed read scenarios plus random transactions,
// each checked cycle by cycle against a bus-phase trace built from the cycle description.
module tb_z80_mem_read_cycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        m1;
  logic [15:0] addr;
  logic [15:0] rfsh_addr;
  logic        busy;
  logic        done;
  logic [7:0]  data_out;
  logic [15:0] bus_a;
  logic        mreq_n;
  logic        rd_n;
  logic        m1_n;
  logic        rfsh_n;
  logic [7:0]  bus_d;
  logic        wait_n;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [7:0]  exp_data = 8'h00;

  z80_mem_read_cycle dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .m1       (m1),
    .addr     (addr),
    .rfsh_addr(rfsh_addr),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .bus_a    (bus_a),
    .mreq_n   (mreq_n),
    .rd_n     (rd_n),
    .m1_n     (m1_n),
    .rfsh_n   (rfsh_n),
    .bus_d    (bus_d),
    .wait_n   (wait_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Snapshot layout: {busy, done, data_out, bus_a, mreq_n, rd_n, m1_n, rfsh_n}
  function automatic logic [29:0] pk(logic b, logic dn, logic [7:0] dt, logic [15:0] ba,
                                     logic mq, logic rd, logic mm, logic rf);
    return {b, dn, dt, ba, mq, rd, mm, rf};
  endfunction

  function automatic logic [29:0] observed();
    return pk(busy, done, data_out, bus_a, mreq_n, rd_n, m1_n, rfsh_n);
  endfunction

  task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_check(input string tag);
    req = 1'b0;
    step();
    check(tag, observed(), pk(1'b0, 1'b0, exp_data, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1));
  endtask

  // Entered while the DUT is idle (or in its done cycle), just after a clock edge.
  task automatic run_txn(input string name, input logic m_i, input logic [15:0] a,
                         input logic [15:0] r, input int nw, input logic [7:0] d,
                         output int done_cyc);
    logic [29:0] q[$];
    logic [7:0]  old;
    int          cap;
    old = exp_data;
    // Address phase: T1, T2 and every wait state present the read address.
    for (int i = 0; i < nw + 2; i++)
      q.push_back(pk(1'b1, 1'b0, old, a, 1'b0, 1'b0, ~m_i, 1'b1));
    if (m_i) begin
      q.push_back(pk(1'b1, 1'b0, d, r, 1'b0, 1'b1, 1'b1, 1'b0));
      q.push_back(pk(1'b1, 1'b0, d, r, 1'b1, 1'b1, 1'b1, 1'b0));
    end else begin
      q.push_back(pk(1'b1, 1'b0, old, a, 1'b0, 1'b0, 1'b1, 1'b1));
    end
    q.push_back(pk(1'b0, 1'b1, d, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1));
    cap = m_i ? nw + 1 : nw + 2;

    req       = 1'b1;
    m1        = m_i;
    addr      = a;
    rfsh_addr = r;
    wait_n    = 1'($urandom);
    bus_d     = 8'($urandom);
    done_cyc  = 0;
    for (int k = 0; k < q.size(); k++) begin
      step();
      check($sformatf("%s cyc%0d", name, k), observed(), q[k]);
      if (k == q.size() - 1) begin
        done_cyc = cyc;
      end else begin
        // Traffic on req/addr while busy must be ignored.
        req       = 1'($urandom);
        m1        = 1'($urandom);
        addr      = 16'($urandom);
        rfsh_addr = 16'($urandom);
        if (k >= 1 && k <= nw) wait_n = 1'b0;
        else if (k == nw + 1)  wait_n = 1'b1;
        else                   wait_n = 1'($urandom);
        bus_d = (k == cap) ? d : 8'($urandom);
      end
    end
    req      = 1'b0;
    exp_data = d;
  endtask

  initial begin
    int dc1;
    int dc2;
    reset     = 1'b1;
    req       = 1'b0;
    m1        = 1'b0;
    addr      = 16'h0000;
    rfsh_addr = 16'h0000;
    bus_d     = 8'h00;
    wait_n    = 1'b1;
    #1;
    check("reset async", observed(), pk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1));
    req = 1'b1;
    step();
    step();
    check("reset held", observed(), pk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1));

    // Abort a plain read while it sits in a wait state.
    reset = 1'b0;
    req   = 1'b1;
    m1    = 1'b0;
    addr  = 16'hBEEF;
    step();
    check("abort T1", observed(), pk(1'b1, 1'b0, 8'h00, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1));
    req    = 1'b0;
    wait_n = 1'b0;
    bus_d  = 8'h5A;
    step();
    step();
    check("abort TW", observed(), pk(1'b1, 1'b0, 8'h00, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1));
    #2 reset = 1'b1;
    #1;
    check("abort immediate", observed(), pk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1));
    wait_n = 1'b1;
    step();
    check("abort no done", observed(), pk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1));
    reset = 1'b0;

    // First request after release is accepted on the first edge.
    run_txn("plain 1234", 1'b0, 16'h1234, 16'h0000, 0, 8'hA5, dc1);
    idle_check("idle after plain");
    run_txn("m1 0100", 1'b1, 16'h0100, 16'h3F7E, 0, 8'h36, dc1);
    idle_check("idle after m1");
    run_txn("plain wait2", 1'b0, 16'h4321, 16'h0000, 2, 8'hC3, dc1);
    idle_check("idle after wait");
    run_txn("m1 wait1", 1'b1, 16'h8000, 16'h0102, 1, 8'h7E, dc1);

    run_txn("b2b 0010", 1'b0, 16'h0010, 16'h0000, 0, 8'h11, dc1);
    run_txn("b2b 0011", 1'b0, 16'h0011, 16'h0000, 0, 8'h22, dc2);
    check("b2b done gap", 30'(dc2 - dc1), 30'd4);
    idle_check("idle after b2b");

    for (int t = 0; t < 40; t++) begin
      run_txn($sformatf("rnd%0d", t), 1'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), 8'($urandom), dc1);
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < int'($urandom_range(1, 2)); g++)
          idle_check($sformatf("rnd%0d idle", t));
      end
    end

    idle_check("final idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z80_mem_read_cycle.md
Z80_MEM_READ_CYCLE -- requirements
Module: z80_mem_read_cycle

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port req  input  1  start request; sampled only in IDLE.
REQ-004 SHALL have port m1  input  1  1 = opcode fetch (M1 cycle with refresh), 0 = plain memory read; sampled with req.
REQ-005 SHALL have port addr  input  16  read address, e.g. HL for LD r,(HL); sampled with req.
REQ-006 SHALL have port rfsh_addr  input  16  refresh address {I,R}; sampled with req.
REQ-007 SHALL have port busy  output  1  1 while in any T-state.
REQ-008 SHALL have port done  output  1  one-cycle pulse: data_out valid.
REQ-009 SHALL have port data_out  output  8  byte captured from bus; held until next capture.
REQ-010 SHALL have port bus_a  output  16  address bus.
REQ-011 SHALL have ports mreq_n, rd_n, m1_n, rfsh_n  output  1 each  active-low bus strobes.
REQ-012 SHALL have port bus_d  input  8  data bus.
REQ-013 SHALL have port wait_n  input  1  active-low wait request.

Function
REQ-014 SHALL implement states IDLE, T1, T2, TW, T3, T4; all outputs registered.
REQ-015 In IDLE with req=1, SHALL latch m1/addr/rfsh_addr and enter T1 next edge; req outside IDLE SHALL be ignored.
REQ-016 On entering T1, SHALL drive bus_a=addr, mreq_n=0, rd_n=0, m1_n=~m1, rfsh_n=1.
REQ-017 T1 SHALL always go to T2.
REQ-018 At the edge leaving T2 or TW, SHALL go to TW if wait_n=0, else to T3; TW repeats indefinitely while wait_n=0.
REQ-019 Plain read: strobes SHALL hold through T3; at edge leaving T3, SHALL capture bus_d into data_out, set mreq_n=rd_n=1, bus_a=0, pulse done, and return to IDLE.
REQ-020 M1 read: at edge leaving T2/TW, SHALL capture bus_d into data_out, then set rd_n=1 and m1_n=1, bus_a=rfsh_addr, rfsh_n=0, mreq_n=0 for T3.
REQ-021 M1 read: entering T4, SHALL set mreq_n=1 and keep rfsh_n=0 and bus_a=rfsh_addr; wait_n SHALL be ignored in T3/T4.
REQ-022 M1 read: at edge leaving T4, SHALL set rfsh_n=1, bus_a=0, pulse done, and return to IDLE.
REQ-023 done SHALL be 1 for exactly the one cycle following the final T-state. busy SHALL be 1 exactly in T1..T4.
REQ-024 req=1 in the done cycle SHALL be accepted (back-to-back cycles, no idle gap).
REQ-025 Latency from req-accept edge to done: plain = 3+Nw cycles; M1 = 4+Nw cycles (Nw = TW count).
REQ-026 data_out SHALL change only at the capture edge.

Reset
REQ-027 While reset=1, SHALL force IDLE, busy=0, done=0, data_out=8'h00, bus_a=16'h0000, mreq_n=rd_n=m1_n=rfsh_n=1.
REQ-028 Reset mid-cycle, including TW, SHALL abort with no done pulse and no data_out update.
REQ-029 First req after reset release SHALL be honored on the first rising edge.

Verification
REQ-030 Plain read with addr=16'h1234, bus_d=8'hA5, wait_n=1 -> bus_a=1234 and mreq_n=rd_n=0 for 3 cycles, m1_n=1, then done=1 with data_out=A5.
REQ-031 M1 read with addr=16'h0100, rfsh_addr=16'h3F7E, bus_d=8'h36, wait_n=1 -> bus_a=0100 for T1-T2 with m1_n=0, data_out=36, bus_a=3F7E with rfsh_n=0 in T3-T4, mreq_n=0 in T3 and 1 in T4, done 4 cycles after accept.
REQ-032 Plain read with wait_n=0 for 2 sampled edges -> exactly 2 TW states, strobes held, done at cycle 5, data sampled at final edge.
REQ-033 Back-to-back reads: req held high, addrs 16'h0010 then 16'h0011 -> second T1 immediately follows the done cycle, and two done pulses 4 cycles apart.
REQ-034 Reset asserted in TW -> all strobes 1 and bus_a=0 immediately, no done, data_out unchanged at 00, and the next req proceeds normally.
REQ-035 req pulsed while busy -> ignored, and the latched addr is unchanged.
